// File: rtl/trace_order_recorder_if.sv
// Handshake and data bundle between the trace front end / spell matcher
// and the trace order recorder.
interface trace_order_recorder_if #(
  parameter int CELLS = 25,
  parameter int IDX_W = 5,
  parameter int DEPTH = 25
) ();
  logic                         start;
  logic                         trace_done;
  logic [CELLS-1:0]             in_trace;
  logic [DEPTH*IDX_W-1:0]       order;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         order_valid;
  logic                         order_ready;
  logic                         overflow;

  modport master (
    output start, trace_done, in_trace, order_ready,
    input  order, count, order_valid, overflow
  );

  modport slave (
    input  start, trace_done, in_trace, order_ready,
    output order, count, order_valid, overflow
  );
endinterface

// File: rtl/trace_order_recorder.sv
// Records the order in which grid cells are first lit (or re-entered when
// REVISIT=1) as a packed list of cell indices, one entry per cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; last list (if any) kept, order_valid low
// CAPTURE | recording one cell per cycle into the next free slot
// HOLD    | list frozen, order_valid high until the consumer accepts it
module trace_order_recorder #(
  parameter int CELLS   = 25,
  parameter int IDX_W   = 5,
  parameter int DEPTH   = 25,
  parameter int REVISIT = 0
) (
  input logic                   clock_i,
  input logic                   resetn_i,
  trace_order_recorder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH*IDX_W-1:0] order_q, order_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic [CELLS-1:0]       seen_q, seen_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [CELLS-1:0]       cand;
  logic                   hit;
  logic [IDX_W-1:0]       idx;
  logic                   recordable;
  logic                   clear;
  logic                   rec;

  // Pick the lowest candidate cell; the sentinel comparison keeps REVISIT
  // from recording the same cell twice in a row.
  always_comb begin
    cand = (REVISIT != 0) ? bus.in_trace : (bus.in_trace & ~seen_q);
    hit  = |cand;
    idx  = SENTINEL;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (cand[i]) idx = IDX_W'(i);
    end
    recordable = hit && ((REVISIT == 0) || (idx != last_q));
  end

  // Next-state, slot write and clear logic; start always wins over trace_done.
  always_comb begin
    state_d    = state_q;
    order_d    = order_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    seen_d     = seen_q;
    last_d     = last_q;
    clear      = 1'b0;
    rec        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.start) begin
          clear = 1'b1;
        end else begin
          rec = recordable;
          if (bus.trace_done) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.order_ready) begin
          if (bus.start) begin
            clear   = 1'b1;
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rec) begin
      if (REVISIT == 0) seen_d[idx] = 1'b1;
      else              last_d      = idx;
      if (count_q == CNT_W'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (count_q == CNT_W'(k)) order_d[k*IDX_W +: IDX_W] = idx;
        end
        count_d = count_q + CNT_W'(1);
      end
    end

    if (clear) begin
      order_d    = '1;
      count_d    = '0;
      overflow_d = 1'b0;
      seen_d     = '0;
      last_d     = SENTINEL;
    end

    valid_d = (state_d == HOLD);
  end

  // State and list registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      order_q    <= '1;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      seen_q     <= '0;
      last_q     <= SENTINEL;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
      last_q     <= last_d;
    end
  end

  assign bus.order       = order_q;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.order_valid = valid_q;

endmodule

// File: tb/tb_trace_order_recorder.sv
// Bench for trace_order_recorder: three configurations share one stimulus
// stream; a queue-style model is compared every cycle and directed literal
// expectations pin the model.
module tb_trace_order_recorder;
  localparam int CELLS = 25;
  localparam int IDX_W = 5;
  localparam logic [124:0] ALL1 = '1;
  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             start;
  logic             trace_done;
  logic             order_ready;
  logic [CELLS-1:0] in_trace;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  trace_order_recorder_if #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(25)) if0 ();
  trace_order_recorder_if #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(4))  if1 ();
  trace_order_recorder_if #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(25)) if2 ();

  assign if0.start = start;  assign if0.trace_done = trace_done;
  assign if0.in_trace = in_trace;  assign if0.order_ready = order_ready;
  assign if1.start = start;  assign if1.trace_done = trace_done;
  assign if1.in_trace = in_trace;  assign if1.order_ready = order_ready;
  assign if2.start = start;  assign if2.trace_done = trace_done;
  assign if2.in_trace = in_trace;  assign if2.order_ready = order_ready;

  trace_order_recorder #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(25), .REVISIT(0)) u0 (
    .clock_i(clk), .resetn_i(resetn), .bus(if0));
  trace_order_recorder #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(4), .REVISIT(0)) u1 (
    .clock_i(clk), .resetn_i(resetn), .bus(if1));
  trace_order_recorder #(.CELLS(CELLS), .IDX_W(IDX_W), .DEPTH(25), .REVISIT(1)) u2 (
    .clock_i(clk), .resetn_i(resetn), .bus(if2));

  // model: per configuration, a list of recorded indices plus bookkeeping
  int               mdepth[3] = '{25, 4, 25};
  int               mrev[3]   = '{0, 0, 1};
  int               mstate[3];
  int               mlist[3][25];
  int               msize[3];
  bit               movf[3];
  logic [CELLS-1:0] mseen[3];
  int               mlast[3];
  int               exp1[5]  = '{12, 7, 2, 3, 4};
  int               path[6]  = '{6, 6, 11, 6, -1, 6};

  function automatic int lowest(input logic [CELLS-1:0] v);
    for (int i = 0; i < CELLS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear(input int j);
    msize[j] = 0;
    movf[j]  = 1'b0;
    mseen[j] = '0;
    mlast[j] = -1;
  endtask

  task automatic model_record(input int j);
    int i;
    if (mrev[j] == 0) begin
      i = lowest(in_trace & ~mseen[j]);
      if (i < 0) return;
      mseen[j][i] = 1'b1;
    end else begin
      i = lowest(in_trace);
      if (i < 0 || i == mlast[j]) return;
      mlast[j] = i;
    end
    if (msize[j] < mdepth[j]) begin
      mlist[j][msize[j]] = i;
      msize[j]++;
    end else begin
      movf[j] = 1'b1;
    end
  endtask

  task automatic model_step(input int j);
    if (!resetn) begin
      model_clear(j);
      mstate[j] = M_IDLE;
    end else begin
      case (mstate[j])
        M_IDLE: if (start) begin model_clear(j); mstate[j] = M_CAP; end
        M_CAP: begin
          if (start) model_clear(j);
          else begin
            model_record(j);
            if (trace_done) mstate[j] = M_HOLD;
          end
        end
        default: begin
          if (order_ready) begin
            if (start) begin model_clear(j); mstate[j] = M_CAP; end
            else mstate[j] = M_IDLE;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) model_step(j);
  end

  task automatic chk_int(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [124:0] act, input logic [124:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot(input logic [124:0] v, input int k);
    return 32'(v[k*IDX_W +: IDX_W]);
  endfunction

  task automatic cmp_inst(input int j, input logic [124:0] a_order, input logic [31:0] a_count,
                          input logic a_valid, input logic a_ovf);
    logic [124:0] e;
    e = '0;
    for (int k = 0; k < mdepth[j]; k++)
      e[k*IDX_W +: IDX_W] = (k < msize[j]) ? 5'(mlist[j][k]) : 5'h1f;
    chk_vec($sformatf("inst%0d order", j), a_order, e);
    chk_int($sformatf("inst%0d count", j), a_count, msize[j]);
    chk_int($sformatf("inst%0d order_valid", j), 32'(a_valid), (mstate[j] == M_HOLD) ? 1 : 0);
    chk_int($sformatf("inst%0d overflow", j), 32'(a_ovf), movf[j] ? 1 : 0);
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, 125'(if0.order), 32'(if0.count), if0.order_valid, if0.overflow);
      cmp_inst(1, 125'(if1.order), 32'(if1.count), if1.order_valid, if1.overflow);
      cmp_inst(2, 125'(if2.order), 32'(if2.count), if2.order_valid, if2.overflow);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; trace_done = 1'b0; order_ready = 1'b0; in_trace = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk_vec("reset order", 125'(if0.order), ALL1);
    chk_int("reset count", 32'(if0.count), 0);
    chk_int("reset valid", 32'(if0.order_valid), 0);
    chk_int("reset overflow", 32'(if0.overflow), 0);
    resetn = 1'b1;

    // ordered lighting 12,7,2,3,4
    start = 1'b1; tick(); start = 1'b0;
    in_trace[12] = 1'b1; tick();
    in_trace[7]  = 1'b1; tick();
    in_trace[2]  = 1'b1; tick();
    in_trace[3]  = 1'b1; tick();
    in_trace[4]  = 1'b1; trace_done = 1'b1; tick(); trace_done = 1'b0;
    chk_int("ordered count", 32'(if0.count), 5);
    for (int k = 0; k < 5; k++) chk_int($sformatf("ordered slot%0d", k), slot(125'(if0.order), k), exp1[k]);
    for (int k = 5; k < 25; k++) chk_int($sformatf("ordered sentinel%0d", k), slot(125'(if0.order), k), 31);
    chk_int("ordered valid", 32'(if0.order_valid), 1);
    chk_int("ordered overflow", 32'(if0.overflow), 0);
    chk_int("depth4 count", 32'(if1.count), 4);
    chk_int("depth4 overflow", 32'(if1.overflow), 1);
    chk_int("revisit cumulative count", 32'(if2.count), 3);

    // hold with consumer stalled; lone start ignored
    in_trace[20] = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    chk_int("hold valid", 32'(if0.order_valid), 1);
    chk_int("hold count", 32'(if0.count), 5);
    chk_int("hold slot0", slot(125'(if0.order), 0), 12);
    order_ready = 1'b1; start = 1'b1; tick();
    order_ready = 1'b0; start = 1'b0; in_trace = '0;
    chk_int("restart count", 32'(if0.count), 0);
    chk_int("restart valid", 32'(if0.order_valid), 0);
    chk_vec("restart order", 125'(if0.order), ALL1);

    // simultaneous bits 9,1,17
    in_trace[9] = 1'b1; in_trace[1] = 1'b1; in_trace[17] = 1'b1;
    tick();
    chk_int("simul count1", 32'(if0.count), 1);
    chk_int("simul slot0", slot(125'(if0.order), 0), 1);
    tick();
    chk_int("simul count2", 32'(if0.count), 2);
    chk_int("simul slot1", slot(125'(if0.order), 1), 9);
    tick();
    chk_int("simul count3", 32'(if0.count), 3);
    chk_int("simul slot2", slot(125'(if0.order), 2), 17);
    trace_done = 1'b1; tick(); trace_done = 1'b0;
    order_ready = 1'b1; tick(); order_ready = 1'b0;
    chk_int("idle valid", 32'(if0.order_valid), 0);
    chk_int("idle count kept", 32'(if0.count), 3);

    // overflow on the DEPTH=4 instance
    in_trace = '0; start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_trace[c] = 1'b1;
      tick();
      chk_int($sformatf("ovf count c%0d", c), 32'(if1.count), (c < 4) ? c + 1 : 4);
      chk_int($sformatf("ovf flag c%0d", c), 32'(if1.overflow), (c >= 4) ? 1 : 0);
    end
    trace_done = 1'b1; tick(); trace_done = 1'b0;
    chk_int("ovf hold flag", 32'(if1.overflow), 1);
    chk_int("ovf hold valid", 32'(if1.order_valid), 1);
    for (int k = 0; k < 4; k++) chk_int($sformatf("ovf slot%0d", k), slot(125'(if1.order), k), k);
    order_ready = 1'b1; tick(); order_ready = 1'b0;

    // REVISIT path 6,6,11,6,none,6
    in_trace = '0; start = 1'b1; tick(); start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      in_trace = '0;
      if (path[p] >= 0) in_trace[path[p]] = 1'b1;
      tick();
    end
    in_trace = '0; trace_done = 1'b1; tick(); trace_done = 1'b0;
    chk_int("revisit count", 32'(if2.count), 3);
    chk_int("revisit slot0", slot(125'(if2.order), 0), 6);
    chk_int("revisit slot1", slot(125'(if2.order), 1), 11);
    chk_int("revisit slot2", slot(125'(if2.order), 2), 6);
    chk_int("revisit slot3", slot(125'(if2.order), 3), 31);
    chk_int("first-visit count on path", 32'(if0.count), 2);
    order_ready = 1'b1; tick(); order_ready = 1'b0;

    // reset mid-capture
    in_trace = '0; start = 1'b1; tick(); start = 1'b0;
    in_trace[3] = 1'b1; tick();
    in_trace[4] = 1'b1; tick();
    in_trace[5] = 1'b1; tick();
    chk_int("pre-reset count", 32'(if0.count), 3);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk_int("midreset count", 32'(if0.count), 0);
    chk_vec("midreset order", 125'(if0.order), ALL1);
    chk_int("midreset valid", 32'(if0.order_valid), 0);
    in_trace[8] = 1'b1; tick(); tick();
    chk_int("idle ignores trace", 32'(if0.count), 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk_int("post-reset count", 32'(if0.count), 1);
    chk_int("post-reset slot0", slot(125'(if0.order), 0), 3);
    start = 1'b1; trace_done = 1'b1; tick(); start = 1'b0; trace_done = 1'b0;
    chk_int("start beats done count", 32'(if0.count), 0);
    chk_int("start beats done valid", 32'(if0.order_valid), 0);
    tick();
    trace_done = 1'b1; tick(); trace_done = 1'b0;
    chk_int("final valid", 32'(if0.order_valid), 1);
    chk_int("final count", 32'(if0.count), 2);
    order_ready = 1'b1; tick(); order_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_order_recorder.md
# trace_order_recorder

Parametrised successor to the static trace-ordering block. It watches a cumulative cell-activation grid from the wand-trace front end and records the order in which cells are first lit, as a packed list of cell indices. It also reports an entry count and an overflow flag. The list is handed to the spell matcher through a valid/ready handshake, and every state change happens on the clock edge.

## Interface
- CELLS, 25, number of grid cells (5x5 default); must satisfy CELLS < 2**IDX_W
- IDX_W, 5, width of one cell index
- DEPTH, 25, number of order slots; 1 <= DEPTH <= CELLS
- REVISIT, 0, 0 = record each cell once (first visit); 1 = also record re-entries (see Operation)

- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  pulse: clear and begin capture
- trace_done  in  1  pulse: end capture
- in_trace  in  CELLS  REVISIT=0: cumulative lit-cell mask; REVISIT=1: one-hot current cell (all-zero = none)
- order  out  DEPTH*IDX_W  slot k at bits [k*IDX_W +: IDX_W]
- count  out  $clog2(DEPTH+1)  valid slots
- order_valid  out  1  list complete and stable
- order_ready  in  1  consumer accepts the list
- overflow  out  1  sticky: a cell was dropped because the list was full

## Operation
- States: IDLE, CAPTURE, HOLD.
- Reset (resetn=0 at an edge, in any state and mid-capture):
  - state=IDLE.
  - Every order slot = all-ones (sentinel 2**IDX_W-1).
  - count=0, overflow=0, order_valid=0, seen mask=0, last index=sentinel.
- IDLE -> CAPTURE on start. The same clear as reset is applied at that edge.
- CAPTURE, REVISIT=0:
  - cand = in_trace & ~seen.
  - If cand is non-zero, the lowest set index i is written to slot[count], count increments, and seen[i] is set.
  - Only one cell is recorded per cycle. If several new cells appear together, they are recorded lowest index first on successive cycles, because in_trace is cumulative.
- CAPTURE, REVISIT=1:
  - Decode the one-hot in_trace to index i.
  - i is recorded when in_trace is non-zero and i != last index. last index is then set to i.
  - If in_trace is not one-hot, the lowest set bit is used.
- Full (count==DEPTH) and a recordable cell arrives:
  - The cell is dropped and overflow is set.
  - REVISIT=0: seen[i] is still set, so overflow is not re-triggered by the same cell.
  - REVISIT=1: last index is updated.
- CAPTURE -> HOLD on trace_done. A cell recordable in the same cycle is still recorded at that edge.
- start during CAPTURE restarts the capture: clear, stay in CAPTURE. start has priority over trace_done.
- HOLD:
  - order_valid=1. order, count and overflow are frozen, and in_trace is ignored.
  - order_valid && order_ready -> IDLE.
  - If start is also high in that cycle -> CAPTURE with clear.
  - start without order_ready is ignored.
- Unwritten slots keep the sentinel. Bits above CELLS never appear as indices.

## Timing
- A cell lit at edge n is sampled in cycle n and appears in order/count after edge n+1 (1-cycle latency).
- order_valid rises on the edge that takes trace_done, and falls on the edge after the handshake cycle.
- Outputs are registered with no combinational path from inputs. Exception: none.
- Throughput: one entry per cycle. A full 25-cell cumulative trace drains in 25 cycles after its last bit is lit.
- All outputs are 0 / sentinel from the first edge with resetn=0.

## Test plan
- Ordered lighting (defaults): start; light cells 12, 7, 2, 3, 4 one per cycle; trace_done. Expected: count=5, slots 0..4 = 12,7,2,3,4, slots 5..24 = 31, order_valid=1, overflow=0.
- Simultaneous bits: in_trace jumps from 0 to bits {9,1,17} in one cycle. Expected: slots record 1, 9, 17 over 3 consecutive cycles; count goes 1, 2, 3.
- Overflow: DEPTH=4; light cells 0..5 cumulatively. Expected: slots = 0,1,2,3; count=4; overflow=1 after cell 4; still 1 in HOLD.
- REVISIT=1: one-hot path 6, 6, 11, 6, none, 6. Expected: slots = 6, 11, 6; count=3. A repeat of 6 after "none" is not recorded, because last index is still 6.
- Handshake/restart: in HOLD, order_ready low for 3 cycles. Expected: order_valid held and outputs frozen. Then start+order_ready together. Expected: next state CAPTURE, count=0, slots = 31.
- Reset mid-capture: resetn=0 for one edge after 3 entries. Expected: count=0, all slots 31, state IDLE, order_valid=0. A subsequent in_trace change is not recorded until start.
